// File: rtl/shreg_pkg.sv
// Shared definitions for both ends of the serial shift-register link.
// The word length lives here so the transmitter and receiver agree on it.
package shreg_pkg;

  localparam int SHREG_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shreg_state_e;

endpackage

// File: rtl/shreg_rx_bitcnt.sv
// Modulo-WIDTH bit counter for the receiver.
// Raises last while sitting on the final bit position of a frame.
module shreg_rx_bitcnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt_r;
  logic          last_s;

  assign last_s = (cnt_r == CW'(WIDTH - 1));
  assign last   = last_s;

  // Counter register: clear wins over increment and the count wraps after the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc) begin
      if (last_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/shreg_rx_chk.sv
// Interface properties of the receiver, kept apart from the datapath.
// q only moves on completion, and an overrun never exists without a pending word.
module shreg_rx_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] q,
  input logic             valid,
  input logic             ovr
);

  a_q_changes_with_valid: assert property (
    @(posedge clk) disable iff (rst) (q != $past(q)) |-> valid
  );

  a_ovr_implies_valid: assert property (
    @(posedge clk) disable iff (rst) ovr |-> valid
  );

endmodule

// File: rtl/shreg_rx.sv
// Serial-in/parallel-out receiver: frames WIDTH MSB-first bits after start and
// hands the word to the consumer over a valid/ack handshake with sticky overrun.
module shreg_rx
  import shreg_pkg::*;
#(
  parameter int WIDTH = SHREG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             si,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             ovr
);

  shreg_state_e     state_r;
  shreg_state_e     state_nxt_s;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] sh_nxt_s;
  logic [WIDTH-1:0] sh_shift_s;
  logic [WIDTH-1:0] q_r;
  logic             valid_r;
  logic             ovr_r;
  logic             clr_s;
  logic             inc_s;
  logic             done_s;
  logic             last_s;

  assign sh_shift_s = {sh_r[WIDTH-2:0], si};

  shreg_rx_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .inc  (inc_s),
    .last (last_s)
  );

  // State and shift register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      sh_r    <= sh_nxt_s;
    end
  end

  // Next-state decode; a start strobe always wins and never captures a bit.
  always_comb begin
    state_nxt_s = state_r;
    sh_nxt_s    = sh_r;
    clr_s       = 1'b0;
    inc_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT;
          sh_nxt_s    = {WIDTH{1'b0}};
          clr_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (start) begin
          state_nxt_s = SHIFT;
          sh_nxt_s    = {WIDTH{1'b0}};
          clr_s       = 1'b1;
        end else if (en) begin
          sh_nxt_s = sh_shift_s;
          inc_s    = 1'b1;
          if (last_s) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        sh_nxt_s    = {WIDTH{1'b0}};
        clr_s       = 1'b1;
      end
    endcase
  end

  // Output word and handshake; an ack coinciding with completion consumes the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (done_s) begin
      q_r     <= sh_shift_s;
      valid_r <= 1'b1;
      if (valid_r) begin
        ovr_r <= ~ack;
      end else begin
        ovr_r <= ovr_r;
      end
    end else if (ack && valid_r) begin
      q_r     <= q_r;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      q_r     <= q_r;
      valid_r <= valid_r;
      ovr_r   <= ovr_r;
    end
  end

  assign q     = q_r;
  assign valid = valid_r;
  assign ovr   = ovr_r;
  assign busy  = (state_r == SHIFT);

  shreg_rx_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .q     (q_r),
    .valid (valid_r),
    .ovr   (ovr_r)
  );

endmodule

// File: tb/tb_shreg_rx.sv
// Directed bench for shreg_rx: inputs change and outputs are sampled on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_shreg_rx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       en;
  logic       si;
  logic       ack;
  logic [7:0] q;
  logic       valid;
  logic       busy;
  logic       ovr;

  int checks;
  int failures;

  shreg_rx #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .en    (en),
    .si    (si),
    .ack   (ack),
    .q     (q),
    .valid (valid),
    .busy  (busy),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one frame. busy_cycles counts samples with busy high from the start
  // edge up to (not including) the completion edge; early flags any change of
  // q or valid before the final bit.
  task automatic do_frame(input logic [7:0] w, input bit gapped, input bit ack_last,
                          output int busy_cycles, output bit early);
    logic [7:0] q0;
    logic       v0;
    q0 = q;
    v0 = valid;
    early = 1'b0;
    start = 1'b1;
    en = 1'b1;
    si = ~w[7];
    @(negedge clk);
    start = 1'b0;
    busy_cycles = int'(busy);
    for (int i = 7; i >= 0; i--) begin
      if (gapped) begin
        en = 1'b0;
        @(negedge clk);
        busy_cycles += int'(busy);
        if (valid !== v0 || q !== q0) early = 1'b1;
      end
      en = 1'b1;
      si = w[i];
      ack = ack_last && (i == 0);
      @(negedge clk);
      ack = 1'b0;
      en = 1'b0;
      if (i > 0) begin
        busy_cycles += int'(busy);
        if (valid !== v0 || q !== q0) early = 1'b1;
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; en = 1'b0; si = 1'b0; ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, valid, busy, ovr} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got q=%h v=%b b=%b o=%b want 00/0/0/0", q, valid, busy, ovr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, valid, busy, ovr} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_idle got q=%h v=%b b=%b o=%b want 00/0/0/0", q, valid, busy, ovr);
    end
  endtask

  task automatic test_basic();
    int bc;
    bit early;
    do_frame(8'hFE, 1'b0, 1'b0, bc, early);
    checks++;
    if ({q, valid, busy, ovr} !== {8'hFE, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_word got q=%h v=%b b=%b o=%b want FE/1/0/0", q, valid, busy, ovr);
    end
    checks++;
    if (bc !== 8 || early !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency got busy_cycles=%0d early=%b want 8/0", bc, early);
    end
    do_ack();
    checks++;
    if ({q, valid, ovr} !== {8'hFE, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_ack got q=%h v=%b o=%b want FE/0/0", q, valid, ovr);
    end
    do_ack();
    checks++;
    if ({q, valid, busy, ovr} !== {8'hFE, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL idle_ack_ignored got q=%h v=%b b=%b o=%b want FE/0/0/0", q, valid, busy, ovr);
    end
  endtask

  task automatic test_gapped();
    int bc;
    bit early;
    do_frame(8'hA5, 1'b1, 1'b0, bc, early);
    checks++;
    if ({q, valid, busy, ovr} !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL gapped_word got q=%h v=%b b=%b o=%b want A5/1/0/0", q, valid, busy, ovr);
    end
    checks++;
    if (bc !== 16 || early !== 1'b0) begin
      failures++;
      $display("FAIL gapped_busy got busy_cycles=%0d early=%b want 16/0", bc, early);
    end
    do_ack();
  endtask

  task automatic test_back_to_back_overrun();
    int bc;
    bit early;
    do_frame(8'h3C, 1'b0, 1'b0, bc, early);
    do_frame(8'hC3, 1'b0, 1'b0, bc, early);
    checks++;
    if ({q, valid, ovr} !== {8'hC3, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL overrun got q=%h v=%b o=%b want C3/1/1", q, valid, ovr);
    end
    do_ack();
    checks++;
    if ({q, valid, ovr} !== {8'hC3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL overrun_ack got q=%h v=%b o=%b want C3/0/0", q, valid, ovr);
    end
  endtask

  task automatic test_ack_collide();
    int bc;
    bit early;
    do_frame(8'h11, 1'b0, 1'b0, bc, early);
    do_frame(8'h22, 1'b0, 1'b1, bc, early);
    checks++;
    if ({q, valid, ovr} !== {8'h22, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ack_collide got q=%h v=%b o=%b want 22/1/0", q, valid, ovr);
    end
    do_ack();
  endtask

  task automatic test_restart();
    int bc;
    bit early;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;
    si = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    do_frame(8'h81, 1'b0, 1'b0, bc, early);
    checks++;
    if ({q, valid, busy, ovr} !== {8'h81, 1'b1, 1'b0, 1'b0} || early !== 1'b0) begin
      failures++;
      $display("FAIL restart_word got q=%h v=%b b=%b o=%b early=%b want 81/1/0/0/0",
               q, valid, busy, ovr, early);
    end
    do_ack();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;
    si = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    si = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en = 1'b0;
    checks++;
    if ({q, valid, busy, ovr} !== {8'h81, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL restart_final got q=%h v=%b b=%b o=%b want 81/0/1/0", q, valid, busy, ovr);
    end
    @(negedge clk);
    checks++;
    if ({q, valid, busy} !== {8'h81, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL restart_hold got q=%h v=%b b=%b want 81/0/1", q, valid, busy);
    end
  endtask

  task automatic test_async_reset();
    int bc;
    bit early;
    do_frame(8'h77, 1'b0, 1'b0, bc, early);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en = 1'b1;
    si = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({q, valid, busy, ovr} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got q=%h v=%b b=%b o=%b want 00/0/0/0", q, valid, busy, ovr);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, valid, busy} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_no_word got q=%h v=%b b=%b want 00/0/0", q, valid, busy);
    end
    do_frame(8'h5A, 1'b0, 1'b0, bc, early);
    checks++;
    if ({q, valid, busy, ovr} !== {8'h5A, 1'b1, 1'b0, 1'b0} || bc !== 8) begin
      failures++;
      $display("FAIL post_reset_word got q=%h v=%b b=%b o=%b bc=%0d want 5A/1/0/0/8",
               q, valid, busy, ovr, bc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back_overrun();
    test_ack_collide();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
